// File: rtl/param_word_serializer.sv
// -----------------------------------------------------------------------------
// param_word_serializer
//   Splits a WIDTH-bit parallel word into NCHUNK = WIDTH/CHUNK chunks of CHUNK
//   bits each, emitted least-significant chunk first. Both sides use a
//   valid/ready handshake. A parent overrides WIDTH/CHUNK by named association.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_data holds a word to send
//   in_ready   out  1      word on in_data is accepted this cycle
//   in_data    in   WIDTH  word to serialise
//   out_valid  out  1      out_data holds a valid chunk
//   out_ready  in   1      downstream consumes the chunk this cycle
//   out_data   out  CHUNK  current chunk
//   out_last   out  1      current chunk is the final chunk of its word
//   out_idx    out  IW     index of the current chunk (0 = LSB chunk)
//   busy       out  1      a word is in flight (same as out_valid)
//
// All outputs except in_ready come straight from registers; in_ready has a
// single combinational dependency on out_ready so a new word can be loaded in
// the same cycle the last chunk of the previous word is consumed.
// -----------------------------------------------------------------------------
module param_word_serializer #(
  parameter  int WIDTH      = 8,
  parameter  int CHUNK      = 4,
  // Guarded divisor keeps elaboration alive long enough to report bad params.
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK,
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE,
  localparam int IW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic [IW-1:0]    out_idx,
  output logic             busy
);

  // Reject shapes that cannot be split into whole chunks.
  generate
    if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
      $error("param_word_serializer: WIDTH must be a positive multiple of CHUNK >= 1");
    end
  endgenerate

  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IW-1:0]    idx_q;
  logic             last_q;
  // Holds in_ready low until the first clock edge after reset release.
  logic             init_q;

  logic             load_d;
  logic [IW-1:0]    idx_d;
  logic             last_d;

  // Handshake acceptance and the index/last values for the next chunk.
  always_comb begin
    in_ready = 1'b0;
    load_d   = 1'b0;
    idx_d    = idx_q;
    last_d   = last_q;
    if (state_q == ST_IDLE) begin
      in_ready = init_q;
    end else begin
      // Back-to-back load: the slot frees up as the final chunk is consumed.
      in_ready = last_q & out_ready;
    end
    load_d = in_valid & in_ready;
    if (last_q) begin
      idx_d  = idx_q;
      last_d = last_q;
    end else begin
      idx_d  = idx_q + {{(IW-1){1'b0}}, 1'b1};
      last_d = (idx_d == LAST_IDX);
    end
  end

  // Serializer FSM: load, shift on consume, return to idle after the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      idx_q   <= {IW{1'b0}};
      last_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      init_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (load_d) begin
            shreg_q <= in_data;
            idx_q   <= {IW{1'b0}};
            last_q  <= (LAST_IDX == {IW{1'b0}});
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (last_q) begin
              if (load_d) begin
                shreg_q <= in_data;
                idx_q   <= {IW{1'b0}};
                last_q  <= (LAST_IDX == {IW{1'b0}});
                state_q <= ST_SEND;
              end else begin
                shreg_q <= {WIDTH{1'b0}};
                idx_q   <= {IW{1'b0}};
                last_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              // Zero-fill shift exposes the next chunk in the low bits.
              shreg_q <= shreg_q >> CHUNK;
              idx_q   <= idx_d;
              last_q  <= last_d;
            end
          end
        end
        default: begin
          shreg_q <= {WIDTH{1'b0}};
          idx_q   <= {IW{1'b0}};
          last_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign out_data  = shreg_q[CHUNK-1:0];
  assign out_last  = last_q;
  assign out_idx   = idx_q;
  assign busy      = out_valid;

  param_word_serializer_chk #(
    .CHUNK    (CHUNK),
    .IW       (IW),
    .LAST_IDX (LAST_IDX)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .busy      (busy)
  );

endmodule

// -----------------------------------------------------------------------------
// param_word_serializer_chk
//   Protocol properties of the serializer output side.
// Ports: clk, rst_n, and the serializer handshake/output signals (all inputs).
// -----------------------------------------------------------------------------
module param_word_serializer_chk #(
  parameter int            CHUNK    = 4,
  parameter int            IW       = 1,
  parameter logic [IW-1:0] LAST_IDX = {IW{1'b0}}
) (
  input logic             clk,
  input logic             rst_n,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [CHUNK-1:0] out_data,
  input logic             out_last,
  input logic [IW-1:0]    out_idx,
  input logic             busy
);

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_idx) && $stable(out_last)));

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    out_idx <= LAST_IDX);

  a_ready_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    (in_ready && out_valid) |-> (out_last && out_ready));

  a_busy_valid: assert property (@(posedge clk) disable iff (!rst_n)
    busy == out_valid);

endmodule

// File: tb/tb_param_word_serializer.sv
module tb_param_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT0: defaults (8/4)
  logic       in_valid0, in_ready0, out_valid0, out_ready0, out_last0, busy0;
  logic [7:0] in_data0;
  logic [3:0] out_data0;
  logic [0:0] out_idx0;
  // DUT1: 16/4
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [15:0] in_data1;
  logic [3:0]  out_data1;
  logic [1:0]  out_idx1;
  // DUT2: 4/4
  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
  logic [3:0] in_data2;
  logic [3:0] out_data2;
  logic [0:0] out_idx2;

  param_word_serializer u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_last(out_last0),
    .out_idx(out_idx0), .busy(busy0));

  param_word_serializer #(.WIDTH(16), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1),
    .out_idx(out_idx1), .busy(busy1));

  param_word_serializer #(.WIDTH(4), .CHUNK(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
    .out_idx(out_idx2), .busy(busy2));

  typedef struct {
    int          dut;
    logic [15:0] data;
    int          idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected chunks of a word: LSB chunk first, last flag on the final one.
  task automatic push_exp(input int d, input logic [15:0] w, input int width, input int chunk);
    exp_t e;
    logic [15:0] mask;
    mask = (16'd1 << chunk) - 16'd1;
    for (int k = 0; k < width / chunk; k++) begin
      e.dut  = d;
      e.data = (w >> (chunk * k)) & mask;
      e.idx  = k;
      e.last = (k == (width / chunk) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic [15:0] data, input logic [7:0] idx, input logic last);
    exp_t e;
    logic [31:0] obs;
    logic [31:0] expv;
    obs = {d[3:0], data, idx, 3'b000, last};
    check("chunk_expected", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      expv = {e.dut[3:0], e.data, e.idx[7:0], 3'b000, e.last};
      check("chunk", obs, expv);
    end
  endtask

  // Scoreboard consumer: every accepted output chunk is compared in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid0 && out_ready0) mon(0, 16'(out_data0), 8'(out_idx0), out_last0);
      if (out_valid1 && out_ready1) mon(1, 16'(out_data1), 8'(out_idx1), out_last1);
      if (out_valid2 && out_ready2) mon(2, 16'(out_data2), 8'(out_idx2), out_last2);
    end
  end

  function automatic logic rdy(input int d);
    case (d)
      0:       return in_ready0;
      1:       return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  task automatic wait_ready(input int d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy(d)) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_in_ready", 32'(ok), 32'd1);
  endtask

  // Present one word, wait for acceptance, then drop in_valid.
  task automatic send(input int d, input logic [15:0] w);
    case (d)
      0: begin in_valid0 = 1'b1; in_data0 = w[7:0]; push_exp(0, w, 8, 4);  end
      1: begin in_valid1 = 1'b1; in_data1 = w;      push_exp(1, w, 16, 4); end
      default: begin in_valid2 = 1'b1; in_data2 = w[3:0]; push_exp(2, w, 4, 4); end
    endcase
    wait_ready(d);
    @(posedge clk); #1;
    case (d)
      0:       in_valid0 = 1'b0;
      1:       in_valid1 = 1'b0;
      default: in_valid2 = 1'b0;
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid0 = 1'b0; in_data0 = 8'h00;  out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_data1 = 16'h0000; out_ready1 = 1'b0;
    in_valid2 = 1'b0; in_data2 = 4'h0;   out_ready2 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({out_valid0, out_data0, out_last0, out_idx0, busy0, in_ready0,
                                out_valid1, in_ready1, out_valid2, in_ready2}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", 32'(in_ready0), 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", 32'(in_ready0), 32'd1);

    // T1: 8'hA5 -> 5, A
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    send(0, 16'h00A5);
    @(negedge clk);
    check("t1_latency", 32'({out_valid0, in_ready0}), 32'(2'b10));
    @(negedge clk);
    check("t1_last_ready", 32'({out_valid0, in_ready0}), 32'(2'b11));
    @(negedge clk);
    check("t1_idle", 32'({out_valid0, busy0, in_ready0}), 32'(3'b001));

    // T2: stall on 8'h3C for 3 cycles
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    send(0, 16'h003C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_hold", 32'({out_valid0, out_data0, out_idx0, out_last0}), 32'({1'b1, 4'hC, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    repeat (3) @(negedge clk);

    // T3: back-to-back 8'h12, 8'h34
    @(posedge clk); #1;
    in_valid0 = 1'b1;
    in_data0  = 8'h12;
    push_exp(0, 16'h0012, 8, 4);
    push_exp(0, 16'h0034, 8, 4);
    wait_ready(0);
    @(posedge clk); #1;
    in_data0 = 8'h34;
    @(negedge clk);
    check("t3_ready_low_chunk0", 32'({out_valid0, in_ready0}), 32'(2'b10));
    @(negedge clk);
    check("t3_ready_high_last", 32'({out_valid0, in_ready0}), 32'(2'b11));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(negedge clk);
    check("t3_no_bubble", 32'({out_valid0, in_ready0}), 32'(2'b10));
    @(negedge clk);
    check("t3_second_last", 32'({out_valid0, in_ready0}), 32'(2'b11));
    @(negedge clk);
    check("t3_idle", 32'({out_valid0, busy0, in_ready0}), 32'(3'b001));

    // T4: 16/4 override, 16'hBEEF -> F,E,E,B
    @(posedge clk); #1;
    out_ready1 = 1'b1;
    send(1, 16'hBEEF);
    repeat (5) @(negedge clk);
    check("t4_idle", 32'({out_valid1, busy1, in_ready1}), 32'(3'b001));

    // T5: reset after first chunk of 8'h77
    @(posedge clk); #1;
    send(0, 16'h0077);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_reset_midword", 32'({out_valid0, out_data0, out_last0, out_idx0, busy0, in_ready0}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 16'h0021);
    repeat (3) @(negedge clk);
    check("t5_idle", 32'({out_valid0, busy0, in_ready0}), 32'(3'b001));

    // T6: WIDTH=CHUNK=4, 4'h9 then 4'h6 back-to-back
    @(posedge clk); #1;
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    in_data2   = 4'h9;
    push_exp(2, 16'h0009, 4, 4);
    push_exp(2, 16'h0006, 4, 4);
    wait_ready(2);
    @(posedge clk); #1;
    in_data2 = 4'h6;
    @(negedge clk);
    check("t6_single_chunk", 32'({out_valid2, out_last2, out_idx2, in_ready2}), 32'(4'b1101));
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    check("t6_next_word", 32'({out_valid2, out_data2, in_ready2}), 32'({1'b1, 4'h6, 1'b1}));
    @(negedge clk);
    check("t6_idle", 32'({out_valid2, busy2, in_ready2}), 32'(3'b001));

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("all_idle", 32'({busy0, busy1, busy2}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
